// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter.
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int DEF_N        = 8;
  localparam int DEF_MAX_HOLD = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational masked priority pick: first set bit of (req & ~exclude) scanning from ptr upward with wrap.
// Zero latency; purely combinational, so there is no backpressure.
import arb_pkg::*;

module rr_priority_pick #(
  parameter int N     = DEF_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N-1:0]     exclude,
  output logic [N-1:0]     pick_oh,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_valid
);

  logic [N-1:0]     w_masked;
  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;

  // Rotating a doubled copy right by ptr puts the scan start at bit 0.
  assign w_masked = req & ~exclude;
  assign w_dbl    = {w_masked, w_masked};
  assign w_rot    = w_dbl[N-1+:N] >> 0 == '0 ? '0 : N'(w_dbl >> ptr);

  always_comb begin
    pick_valid = 1'b0;
    w_off      = '0;
    for (int j = 0; j < N; j++) begin
      if (!pick_valid && w_rot[j]) begin
        pick_valid = 1'b1;
        w_off      = j[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    if (w_sum >= (IDX_W+1)'(N)) begin
      w_sum = w_sum - (IDX_W+1)'(N);
    end
  end

  assign pick_idx = pick_valid ? w_sum[IDX_W-1:0] : '0;
  assign pick_oh  = pick_valid ? (N'(1) << pick_idx) : '0;

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter with hold-while-requesting and a hold timeout that preempts the owner.
// gnt/gnt_idx are registered (one cycle after the request is seen); en=0 blocks new grants but never revokes one.
import arb_pkg::*;

module rr_arbiter_ctrl #(
  parameter int N        = DEF_N,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        r_state;
  logic [N-1:0]      r_gnt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_ptr;
  logic [HOLD_W-1:0] r_hold;
  logic              r_preempt;

  logic [N-1:0]      w_exclude;
  logic [N-1:0]      w_pick_oh;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_valid;
  logic              w_load;
  logic              w_go_idle;
  logic              w_pre;
  logic [HOLD_W-1:0] w_hold_nxt;

  // The current owner never competes against itself when rotating away.
  assign w_exclude = (r_state == GRANT) ? r_gnt : '0;

  rr_priority_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req        (req),
    .ptr        (r_ptr),
    .exclude    (w_exclude),
    .pick_oh    (w_pick_oh),
    .pick_idx   (w_pick_idx),
    .pick_valid (w_pick_valid)
  );

  always_comb begin
    w_load     = 1'b0;
    w_go_idle  = 1'b0;
    w_pre      = 1'b0;
    w_hold_nxt = r_hold;
    case (r_state)
      IDLE: begin
        w_load = en && w_pick_valid;
      end
      GRANT: begin
        if (!req[r_idx]) begin
          if (en && w_pick_valid) w_load = 1'b1;
          else                    w_go_idle = 1'b1;
        end else if (r_hold == HOLD_LAST && w_pick_valid && en) begin
          w_load = 1'b1;
          w_pre  = 1'b1;
        end else if (r_hold != HOLD_LAST) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: w_go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= w_pre;
      if (w_load) begin
        r_state <= GRANT;
        r_gnt   <= w_pick_oh;
        r_idx   <= w_pick_idx;
        r_ptr   <= (w_pick_idx == IDX_W'(N - 1)) ? '0 : w_pick_idx + 1'b1;
        r_hold  <= '0;
      end else if (w_go_idle) begin
        r_state <= IDLE;
        r_gnt   <= '0;
        r_idx   <= '0;
        r_hold  <= '0;
      end else begin
        r_hold  <= w_hold_nxt;
      end
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = |r_gnt;
  assign preempt   = r_preempt;

endmodule
